// File: rtl/master_control_if.sv
// ---------------------------------------------------------------------------
// master_control_if
// Purpose : bundles the local-logic and responder signals of master_control.
// Signals : start, tx_data            - transfer request and payload from local logic
//           ack, notice               - responder acknowledge / "request seen" hint
//           request, valid, data      - request, data strobe and payload to responder
//           busy, done, error, pending - transfer status back to local logic
// Modports: master - the master_control side; slave - the driving environment.
// ---------------------------------------------------------------------------
interface master_control_if #(
    parameter int DATA_W = 3
);
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              ack;
    logic              notice;
    logic              request;
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              busy;
    logic              done;
    logic              error;
    logic              pending;

    modport master (
        input  start, tx_data, ack, notice,
        output request, valid, data, busy, done, error, pending
    );

    modport slave (
        output start, tx_data, ack, notice,
        input  request, valid, data, busy, done, error, pending
    );
endinterface

// File: rtl/master_control.sv
// ---------------------------------------------------------------------------
// master_control
// Purpose : two-phase handshake master. A local start launches a request to a
//           responder; the first ack grants it and the payload is strobed for
//           one cycle; the second ack confirms capture and pulses done. A
//           bounded timer aborts a stalled REQ or WAIT_ACCEPT with an error.
// Ports   : clk   - single clock, rising edge
//           rst   - asynchronous active-high reset
//           bus   - master_control_if.master (start/tx_data/ack/notice in,
//                   request/valid/data/busy/done/error/pending out)
// Params  : DATA_W  - payload width
//           TIMEOUT - cycles allowed in REQ or WAIT_ACCEPT (2..255)
// ---------------------------------------------------------------------------
module master_control #(
    parameter int DATA_W  = 3,
    parameter int TIMEOUT = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    master_control_if.master     bus
);
    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        REQ         = 2'd1,
        SEND        = 2'd2,
        WAIT_ACCEPT = 2'd3
    } state_t;

    // Timer wide enough for the largest legal TIMEOUT.
    localparam logic [7:0] TMR_LAST = 8'(TIMEOUT - 1);

    state_t            r_state,   w_state_next;
    logic              r_request, w_request_next;
    logic              r_valid,   w_valid_next;
    logic [DATA_W-1:0] r_data,    w_data_next;
    logic              r_busy,    w_busy_next;
    logic              r_done,    w_done_next;
    logic              r_error,   w_error_next;
    logic              r_pending, w_pending_next;
    logic [7:0]        r_timer,   w_timer_next;
    logic [DATA_W-1:0] r_hold,    w_hold_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_request <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_pending <= 1'b0;
            r_timer   <= '0;
            r_hold    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_request <= w_request_next;
            r_valid   <= w_valid_next;
            r_data    <= w_data_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_error   <= w_error_next;
            r_pending <= w_pending_next;
            r_timer   <= w_timer_next;
            r_hold    <= w_hold_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_request_next = r_request;
        w_valid_next   = r_valid;
        w_data_next    = r_data;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;          // done and error are single-cycle pulses
        w_error_next   = 1'b0;
        w_pending_next = r_pending;
        w_timer_next   = r_timer;
        w_hold_next    = r_hold;

        unique case (r_state)
            IDLE: begin
                w_request_next = 1'b0;
                w_valid_next   = 1'b0;
                w_busy_next    = 1'b0;
                w_pending_next = 1'b0;
                // A start coinciding with the done pulse is dropped so that
                // back-to-back transfers always see one clean idle edge.
                if (bus.start && !r_done) begin
                    w_hold_next    = bus.tx_data;
                    w_request_next = 1'b1;
                    w_busy_next    = 1'b1;
                    w_timer_next   = '0;
                    w_state_next   = REQ;
                end
            end

            REQ: begin
                // ack is tested before the timer so a grant on the last
                // allowed cycle still wins over the abort.
                if (bus.ack) begin
                    w_request_next = 1'b0;
                    w_valid_next   = 1'b1;
                    w_data_next    = r_hold;
                    w_pending_next = 1'b0;
                    w_state_next   = SEND;
                end else if (r_timer == TMR_LAST) begin
                    w_request_next = 1'b0;
                    w_busy_next    = 1'b0;
                    w_pending_next = 1'b0;
                    w_error_next   = 1'b1;
                    w_state_next   = IDLE;
                end else begin
                    w_timer_next = r_timer + 8'd1;
                    if (bus.notice) begin
                        w_pending_next = 1'b1;
                    end
                end
            end

            SEND: begin
                // ack is ignored here: valid is strobed exactly once.
                w_valid_next = 1'b0;
                w_timer_next = '0;
                w_state_next = WAIT_ACCEPT;
            end

            WAIT_ACCEPT: begin
                if (bus.ack) begin
                    w_done_next  = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = IDLE;
                end else if (r_timer == TMR_LAST) begin
                    w_error_next = 1'b1;
                    w_busy_next  = 1'b0;
                    w_state_next = IDLE;
                end else begin
                    w_timer_next = r_timer + 8'd1;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.request = r_request;
    assign bus.valid   = r_valid;
    assign bus.data    = r_data;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.error   = r_error;
    assign bus.pending = r_pending;

endmodule

// File: tb/tb_master_control.sv
// ---------------------------------------------------------------------------
// tb_master_control
// Drives master_control (DATA_W=3, TIMEOUT=8) with directed and randomized
// transfers. Expected outputs are derived per cycle from a transfer timeline
// (grant edge, accept edge, notice window) and compared through check_value.
// A behavioural responder closes the loop for consecutive transfers.
// ---------------------------------------------------------------------------
module tb_master_control;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    master_control_if #(.DATA_W(3)) bus ();

    master_control #(.DATA_W(3), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Local drive vs. responder drive of ack/notice.
    logic drv_ack = 1'b0;
    logic drv_notice = 1'b0;
    logic resp_en = 1'b0;
    logic resp_ack, resp_notice;
    assign bus.ack    = resp_en ? resp_ack    : drv_ack;
    assign bus.notice = resp_en ? resp_notice : drv_notice;

    logic [2:0] last_data = 3'b000;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] obs();
        return {bus.request, bus.valid, bus.data, bus.busy, bus.done, bus.error, bus.pending};
    endfunction

    function automatic logic [8:0] pack(bit req, bit val, logic [2:0] d, bit bsy, bit dn, bit er, bit pd);
        return {req, val, d, bsy, dn, er, pd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer. g: REQ edge at which ack-grant is sampled (>TO => none);
    // a: WAIT_ACCEPT edge at which ack-accept is sampled (>TO => none);
    // notice high on REQ edges nf..nf+nl-1; poke re-asserts start mid-transfer.
    task automatic run_transfer(input logic [2:0] d, input int g, input int a,
                                input int nf, input int nl, input bit poke, input string name);
        bit pend;
        bit granted;
        bit done_seen;
        int errs0;
        errs0     = n_errors;
        pend      = 1'b0;
        granted   = 1'b0;
        done_seen = 1'b0;

        bus.start = 1'b1; bus.tx_data = d; drv_ack = 1'b0; drv_notice = 1'b0;
        tick();
        bus.start = 1'b0; bus.tx_data = 3'($urandom);
        check_value({name, ":accept"}, 32'(obs()), 32'(pack(1, 0, last_data, 1, 0, 0, 0)));

        for (int k = 1; k <= TO; k++) begin
            drv_ack    = (k == g);
            drv_notice = (k >= nf) && (k < nf + nl);
            bus.start  = poke;
            if (poke) bus.tx_data = 3'($urandom);
            tick();
            if (k == g) begin
                last_data = d;
                granted   = 1'b1;
                check_value({name, ":grant"}, 32'(obs()), 32'(pack(0, 1, d, 1, 0, 0, 0)));
                break;
            end else if (k == TO) begin
                check_value({name, ":req_timeout"}, 32'(obs()), 32'(pack(0, 0, last_data, 0, 0, 1, 0)));
            end else begin
                pend = pend | drv_notice;
                check_value({name, ":req"}, 32'(obs()), 32'(pack(1, 0, last_data, 1, 0, 0, pend)));
            end
        end

        if (granted) begin
            drv_ack = 1'($urandom);          // must be ignored while valid is up
            drv_notice = 1'b0;
            tick();
            check_value({name, ":send"}, 32'(obs()), 32'(pack(0, 0, d, 1, 0, 0, 0)));
            for (int m = 1; m <= TO; m++) begin
                drv_ack = (m == a);
                tick();
                if (m == a) begin
                    done_seen = 1'b1;
                    check_value({name, ":done"}, 32'(obs()), 32'(pack(0, 0, d, 0, 1, 0, 0)));
                    break;
                end else if (m == TO) begin
                    check_value({name, ":wait_timeout"}, 32'(obs()), 32'(pack(0, 0, d, 0, 0, 1, 0)));
                end else begin
                    check_value({name, ":wait"}, 32'(obs()), 32'(pack(0, 0, d, 1, 0, 0, 0)));
                end
            end
        end

        drv_ack = 1'b0; drv_notice = 1'b0; bus.start = 1'b0;
        if (done_seen) begin
            // start during the done cycle must be dropped
            bus.start = 1'b1; bus.tx_data = 3'($urandom);
            tick();
            bus.start = 1'b0;
            check_value({name, ":start_in_done"}, 32'(obs()), 32'(pack(0, 0, last_data, 0, 0, 0, 0)));
        end
        $display("xfer %s data=%b grant=%0d accept=%0d poke=%0d -> %s",
                 name, d, g, a, poke, (n_errors == errs0) ? "ok" : "bad");
    endtask

    // Behavioural responder with active-low reset.
    logic resp_rst_n;
    assign resp_rst_n = ~rst;
    int phase;
    int cnt;
    logic [2:0] cap_q[$];

    always @(posedge clk or negedge resp_rst_n) begin
        if (!resp_rst_n) begin
            phase <= 0; cnt <= 0; resp_ack <= 1'b0; resp_notice <= 1'b0;
        end else if (!resp_en) begin
            phase <= 0; resp_ack <= 1'b0; resp_notice <= 1'b0;
            cnt <= int'($urandom_range(0, 4));
        end else begin
            case (phase)
                0: if (bus.request) begin
                       if (cnt != 0) begin
                           cnt <= cnt - 1; resp_notice <= 1'b1;
                       end else begin
                           resp_ack <= 1'b1; resp_notice <= 1'b0; phase <= 1;
                       end
                   end
                1: begin
                       resp_ack <= 1'b0;
                       if (bus.valid) begin
                           cap_q.push_back(bus.data);
                           cnt <= int'($urandom_range(0, 4));
                           phase <= 2;
                       end
                   end
                2: if (cnt != 0) cnt <= cnt - 1;
                   else begin resp_ack <= 1'b1; phase <= 3; end
                default: begin
                       resp_ack <= 1'b0;
                       cnt <= int'($urandom_range(0, 4));
                       phase <= 0;
                   end
            endcase
        end
    end

    initial begin
        logic [2:0] loop_vals [3];
        loop_vals[0] = 3'b001; loop_vals[1] = 3'b110; loop_vals[2] = 3'b011;
        bus.start = 1'b0; bus.tx_data = 3'b000;

        // reset state
        #12;
        check_value("reset_state", 32'(obs()), 32'(pack(0, 0, 3'b000, 0, 0, 0, 0)));
        @(negedge clk); rst = 1'b0;

        // directed cases
        run_transfer(3'b101, 5, 2, 1, 4, 1'b0, "nominal");
        run_transfer(3'b011, TO + 1, 1, 2, 2, 1'b0, "req_timeout");
        run_transfer(3'b110, 2, TO + 1, 9, 0, 1'b0, "wait_timeout");
        run_transfer(3'b111, 3, 3, 9, 0, 1'b1, "start_in_req");
        run_transfer(3'b010, TO, TO, 1, 8, 1'b0, "ack_at_limit");
        run_transfer(3'b100, 1, 1, 9, 0, 1'b0, "fastest");

        // randomized transfers
        for (int i = 0; i < 16; i++) begin
            run_transfer(3'($urandom), int'($urandom_range(1, TO + 1)), int'($urandom_range(1, TO + 1)),
                         int'($urandom_range(1, 6)), int'($urandom_range(0, 4)),
                         1'($urandom_range(0, 1)), "rand");
        end

        // asynchronous reset while valid is high
        bus.start = 1'b1; bus.tx_data = 3'b110; tick();
        bus.start = 1'b0; drv_ack = 1'b1; tick();
        drv_ack = 1'b0;
        check_value("pre_reset_valid", 32'(bus.valid), 32'(1));
        #3 rst = 1'b1;
        #1;
        check_value("async_reset", 32'(obs()), 32'(pack(0, 0, 3'b000, 0, 0, 0, 0)));
        last_data = 3'b000;
        @(posedge clk); #2 rst = 1'b0;
        $display("xfer async_reset mid-valid -> outputs cleared");
        run_transfer(3'b011, 2, 2, 1, 1, 1'b0, "after_reset");

        // closed loop against the responder
        resp_en = 1'b1;
        tick();
        for (int v = 0; v < 3; v++) begin
            bit fin;
            fin = 1'b0;
            bus.start = 1'b1; bus.tx_data = loop_vals[v]; tick();
            bus.start = 1'b0;
            for (int c = 0; c < 40; c++) begin
                tick();
                if (bus.done || bus.error) begin fin = 1'b1; break; end
            end
            check_value("loop_done", 32'({fin, bus.done, bus.error}), 32'(3'b110));
            $display("xfer loop data=%b done=%0d error=%0d", loop_vals[v], bus.done, bus.error);
            tick();
        end
        for (int c = 0; c < 10; c++) tick();
        resp_en = 1'b0;
        check_value("loop_captures", 32'(cap_q.size()), 32'(3));
        for (int v = 0; v < 3; v++) begin
            if (v < cap_q.size())
                check_value("loop_capture_value", 32'(cap_q[v]), 32'(loop_vals[v]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
